// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and the
// signed-overflow equation used when the result registers load.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Subtraction overflows only when operand signs differ and the result
    // sign disagrees with the minuend sign.
    function automatic logic calc_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic diff_msb
    );
        return (a_msb != b_msb) && (diff_msb != a_msb);
    endfunction

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   master : producer of operands and consumer of results (drives in_valid,
//            a, b, borrow_in, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid, diff, borrow_out,
//            overflow)
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit combinational full subtractor cell: d = a - b - bin.
//   a, b, bin : input bits (bin is the borrow in)
//   d         : difference bit
//   bout      : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they tie and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in,
// one bit per clock, LSB first, WIDTH cycles per operation.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of serial_subtractor_if
//              in_valid/in_ready  operand handshake (ready only when idle)
//              a, b, borrow_in    operands
//              out_valid/out_ready result handshake (result held until taken)
//              diff, borrow_out, overflow  registered result
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] diff_final_c;

    // Single shared bit cell fed from the LSBs of the operand shift registers.
    full_subtractor u_full_subtractor (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // Result as it will look once the current bit is shifted in.
    assign diff_final_c = {d_bit, d_sr[WIDTH-1:1]};

    // FSM, datapath shift registers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            d_sr        <= '0;
            br          <= 1'b0;
            cnt         <= '0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sr       <= bus.a;
                        b_sr       <= bus.b;
                        br         <= bus.borrow_in;
                        cnt        <= '0;
                        a_msb      <= bus.a[WIDTH-1];
                        b_msb      <= bus.b[WIDTH-1];
                        in_ready_q <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr <= diff_final_c;
                    br   <= br_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        diff_q      <= diff_final_c;
                        borrow_q    <= br_next;
                        overflow_q  <= calc_overflow(a_msb, b_msb, d_bit);
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // in_ready is re-armed only here, so the next accept is
                    // at least one edge after the result handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = overflow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed corner
// cases, backpressure, mid-operation reset and randomized operations
// compared against an integer-arithmetic reference.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_model(input int a, input int b, input int bin,
                             output logic [W-1:0] e_diff, output logic e_bout,
                             output logic e_ovf);
        int r, sa, sb, sr;
        r      = a - b - bin;
        e_diff = W'(r);
        e_bout = (a < b + bin);
        sa     = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
        sb     = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
        sr     = sa - sb - bin;
        e_ovf  = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
    endtask

    // Waits for in_ready, presents operands and returns just after the accept edge.
    task automatic start_op(input int a, input int b, input int bin);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = W'(a);
        bus.b         = W'(b);
        bus.borrow_in = 1'(bin);
        @(negedge clk);
        // Scramble inputs; they must not disturb the running operation.
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.borrow_in = 1'($urandom_range(0, 1));
    endtask

    // Waits for the result, checks latency and values, holds off out_ready
    // for 'hold' cycles, then completes the handshake.
    task automatic finish_op(input int a, input int b, input int bin, input int hold,
                             input string tag);
        logic [W-1:0] e_diff;
        logic         e_bout, e_ovf;
        int           lat;
        ref_model(a, b, bin, e_diff, e_bout, e_ovf);
        bus.out_ready = (hold == 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid !== 1'b1) bus.in_valid = 1'($urandom_range(0, 1));
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_diff"}, 32'(bus.diff), 32'(e_diff));
        check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e_bout));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(e_ovf));
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_diff"}, {bus.diff, bus.borrow_out, bus.overflow, bus.in_ready},
                  {e_diff, e_bout, e_ovf, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_diff_held"}, 32'(bus.diff), 32'(e_diff));
        bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input int a, input int b, input int bin, input int hold,
                          input string tag);
        start_op(a, b, bin);
        finish_op(a, b, bin, hold, tag);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs", {bus.diff, bus.borrow_out, bus.overflow}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(7, 3, 0, 0, "d7m3");
        run_op(3, 7, 0, 0, "d3m7");
        run_op(8, 1, 0, 0, "neg8m1");
        run_op(8, 0, 1, 0, "neg8m0b");
        run_op(0, 0, 1, 0, "zero_b");
        run_op(6, 9, 1, 5, "backpr");
        run_op(2, 14, 0, 0, "after_bp");

        // Abort during the second shift cycle; previous result is nonzero.
        start_op(9, 2, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {bus.diff, bus.borrow_out, bus.overflow}, '0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        run_op(5, 5, 0, 0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_subtractor
